// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer with 2-bit counters, an INIT clearing walk and mispredict redirect.
// Optional BPU_STATS_EN macro adds lookup/mispredict performance counters.
module bpu_btb #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned TAG_W   = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fe_valid,
    input  logic [31:0] fe_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        upd_uncond,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    input  logic        inv_all,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        ready,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_mispredicts
);
    localparam int unsigned INDEX_W = $clog2(ENTRIES);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state, state_nx;
    logic [INDEX_W-1:0] walk_idx, walk_nx;

    logic               tbl_valid  [ENTRIES];
    logic [TAG_W-1:0]   tbl_tag    [ENTRIES];
    logic [31:0]        tbl_target [ENTRIES];
    logic [1:0]         tbl_ctr    [ENTRIES];

    logic [INDEX_W-1:0] fe_idx, upd_idx, w_idx;
    logic [TAG_W-1:0]   fe_tag, upd_tag, w_tag;
    logic               fe_hit, fe_taken, upd_hit, mispredict;
    logic               we, w_valid;
    logic [31:0]        w_target;
    logic [1:0]         w_ctr, upd_ctr;

    assign fe_idx  = fe_pc[INDEX_W+1:2];
    assign fe_tag  = fe_pc[INDEX_W+TAG_W+1:INDEX_W+2];
    assign upd_idx = upd_pc[INDEX_W+1:2];
    assign upd_tag = upd_pc[INDEX_W+TAG_W+1:INDEX_W+2];

    // Table reads are combinational; the write lands at the same edge, so a colliding lookup sees old contents.
    assign fe_hit   = tbl_valid[fe_idx] && (tbl_tag[fe_idx] == fe_tag);
    assign fe_taken = (state == ST_RUN) && fe_hit && tbl_ctr[fe_idx][1];
    assign upd_hit  = tbl_valid[upd_idx] && (tbl_tag[upd_idx] == upd_tag);
    assign upd_ctr  = tbl_ctr[upd_idx];

    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && upd_pred_taken && (upd_pred_target != upd_target)));

    assign ready = (state == ST_RUN);

    always_comb begin
        state_nx = state;
        walk_nx  = walk_idx;
        case (state)
            ST_INIT: begin
                if (inv_all) begin
                    walk_nx = '0;
                end else if (walk_idx == INDEX_W'(ENTRIES - 1)) begin
                    state_nx = ST_RUN;
                    walk_nx  = '0;
                end else begin
                    walk_nx = walk_idx + INDEX_W'(1);
                end
            end
            ST_RUN: begin
                if (inv_all) begin
                    state_nx = ST_INIT;
                    walk_nx  = '0;
                end
            end
        endcase
    end

    always_comb begin
        we       = 1'b0;
        w_idx    = upd_idx;
        w_valid  = 1'b1;
        w_tag    = upd_tag;
        w_target = tbl_target[upd_idx];
        w_ctr    = upd_ctr;
        if (state == ST_INIT) begin
            we      = 1'b1;
            w_idx   = walk_idx;
            w_valid = 1'b0;
            w_ctr   = 2'd1;
        end else if (upd_valid && !inv_all) begin
            if (upd_hit) begin
                we = 1'b1;
                if (upd_taken) w_target = upd_target;
                if (upd_uncond)
                    w_ctr = 2'd3;
                else if (upd_taken)
                    w_ctr = (upd_ctr == 2'd3) ? 2'd3 : upd_ctr + 2'd1;
                else
                    w_ctr = (upd_ctr == 2'd0) ? 2'd0 : upd_ctr - 2'd1;
            end else if (upd_taken) begin
                we       = 1'b1;
                w_target = upd_target;
                w_ctr    = upd_uncond ? 2'd3 : 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tbl_valid[w_idx]  <= w_valid;
            tbl_tag[w_idx]    <= w_tag;
            tbl_target[w_idx] <= w_target;
            tbl_ctr[w_idx]    <= w_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= ST_INIT;
            walk_idx       <= '0;
            pred_valid     <= 1'b0;
            pred_taken     <= 1'b0;
            pred_target    <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_nx;
            walk_idx       <= walk_nx;
            pred_valid     <= fe_valid;
            pred_taken     <= fe_valid && fe_taken;
            pred_target    <= fe_taken ? tbl_target[fe_idx] : fe_pc + 32'd4;
            redirect_valid <= mispredict;
            if (mispredict)
                redirect_pc <= upd_taken ? upd_target : upd_pc + 32'd4;
        end
    end

`ifdef BPU_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (fe_valid)   stat_lookups     <= stat_lookups + 32'd1;
            if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`else
    assign stat_lookups     = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_bpu_btb.sv
// Directed self-checking bench for bpu_btb (ENTRIES=64, TAG_W=8).
module tb_bpu_btb;
    logic        clk = 1'b0;
    logic        resetn;
    logic        fe_valid;
    logic [31:0] fe_pc;
    logic        pred_valid, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc, upd_target;
    logic        upd_taken, upd_uncond, upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        inv_all;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ready;
    logic [31:0] stat_lookups, stat_mispredicts;

    int tests = 0;
    int fails = 0;
    int cnt;

    always #5 clk = ~clk;

    bpu_btb #(.ENTRIES(64), .TAG_W(8)) dut (
        .clk(clk), .resetn(resetn),
        .fe_valid(fe_valid), .fe_pc(fe_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_uncond(upd_uncond),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .inv_all(inv_all),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ready(ready),
        .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
    );

    function automatic logic [31:0] stat_exp(input logic [31:0] v);
`ifdef BPU_STATS_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        fe_valid = 1'b1;
        fe_pc    = pc;
        step();
        fe_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                          input logic unc, input logic ptk, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_target      = tgt;
        upd_taken       = tk;
        upd_uncond      = unc;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic wait_ready(input int start, output int n);
        n = start;
        while (ready !== 1'b1 && n < 300) begin
            step();
            n++;
        end
    endtask

    initial begin
        resetn = 1'b0; fe_valid = 1'b0; fe_pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_target = '0; upd_taken = 1'b0; upd_uncond = 1'b0; upd_pred_taken = 1'b0;
        upd_pred_target = '0; inv_all = 1'b0;
        repeat (3) step();
        chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'd0);
        chk("rst_redir_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redir_pc", redirect_pc, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_stat_lk", stat_lookups, 32'd0);
        chk("rst_stat_mp", stat_mispredicts, 32'd0);

        resetn = 1'b1;
        wait_ready(0, cnt);
        chk("init_len", cnt, 32'd64);

        lookup(32'h0040_0000);
        chk("cold_valid", {31'd0, pred_valid}, 32'd1);
        chk("cold_taken", {31'd0, pred_taken}, 32'd0);
        chk("cold_target", pred_target, 32'h0040_0004);

        // Correctly predicted taken update: allocates with counter 2, no redirect
        update(32'h0040_0010, 32'h0040_0100, 1'b1, 1'b0, 1'b1, 32'h0040_0100);
        chk("noredir", {31'd0, redirect_valid}, 32'd0);
        chk("idle_pred_valid", {31'd0, pred_valid}, 32'd0);
        lookup(32'h0040_0010);
        chk("alloc_taken", {31'd0, pred_taken}, 32'd1);
        chk("alloc_target", pred_target, 32'h0040_0100);

        update(32'h0040_0010, 32'h0040_0100, 1'b0, 1'b0, 1'b1, 32'h0040_0100);
        chk("nt_redir_pc", redirect_pc, 32'h0040_0014);
        update(32'h0040_0010, 32'h0040_0100, 1'b0, 1'b0, 1'b1, 32'h0040_0100);
        lookup(32'h0040_0010);
        chk("dec_taken", {31'd0, pred_taken}, 32'd0);
        chk("dec_target", pred_target, 32'h0040_0014);

        update(32'h0040_0040, 32'h0040_0200, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("mp1_valid", {31'd0, redirect_valid}, 32'd1);
        chk("mp1_pc", redirect_pc, 32'h0040_0200);
        update(32'h0040_0020, 32'h0040_0900, 1'b0, 1'b0, 1'b1, 32'h0040_0900);
        chk("mp2_valid", {31'd0, redirect_valid}, 32'd1);
        chk("mp2_pc", redirect_pc, 32'h0040_0024);
        step();
        chk("mp_clear", {31'd0, redirect_valid}, 32'd0);

        // Lookup and allocating update to the same index in one cycle
        fe_valid = 1'b1; fe_pc = 32'h0040_0030;
        update(32'h0040_0030, 32'h0040_0300, 1'b1, 1'b0, 1'b1, 32'h0040_0300);
        fe_valid = 1'b0;
        chk("coll_taken", {31'd0, pred_taken}, 32'd0);
        chk("coll_target", pred_target, 32'h0040_0034);
        lookup(32'h0040_0030);
        chk("coll_next_taken", {31'd0, pred_taken}, 32'd1);
        chk("coll_next_target", pred_target, 32'h0040_0300);

        // Aliasing: 0x0040_1010 shares index 4 with 0x0040_0010 but has tag 0x10
        update(32'h0040_0010, 32'h0040_0110, 1'b1, 1'b1, 1'b1, 32'h0040_0110);
        lookup(32'h0040_0010);
        chk("unc_target", pred_target, 32'h0040_0110);
        update(32'h0040_1010, 32'h0040_0500, 1'b1, 1'b0, 1'b1, 32'h0040_0500);
        lookup(32'h0040_1010);
        chk("alias_new_target", pred_target, 32'h0040_0500);
        lookup(32'h0040_0010);
        chk("alias_old_taken", {31'd0, pred_taken}, 32'd0);
        chk("alias_old_target", pred_target, 32'h0040_0014);

        // inv_all in RUN; lookups answer and updates are dropped during the walk
        inv_all = 1'b1; step(); inv_all = 1'b0;
        chk("inv_ready", {31'd0, ready}, 32'd0);
        lookup(32'h0040_0030);
        chk("init_lk_valid", {31'd0, pred_valid}, 32'd1);
        chk("init_lk_taken", {31'd0, pred_taken}, 32'd0);
        chk("init_lk_target", pred_target, 32'h0040_0034);
        update(32'h0040_0050, 32'h0040_0700, 1'b1, 1'b1, 1'b1, 32'h0040_0700);
        wait_ready(2, cnt);
        chk("inv_len", cnt, 32'd64);
        lookup(32'h0040_0030);
        chk("inv_miss", {31'd0, pred_taken}, 32'd0);
        lookup(32'h0040_0050);
        chk("init_upd_ignored", {31'd0, pred_taken}, 32'd0);

        // inv_all mid-walk restarts at index 0
        inv_all = 1'b1; step(); inv_all = 1'b0;
        repeat (10) step();
        inv_all = 1'b1; step(); inv_all = 1'b0;
        wait_ready(0, cnt);
        chk("inv_restart_len", cnt, 32'd64);

        // Reset mid-RUN, then again mid-walk
        update(32'h0040_0030, 32'h0040_0300, 1'b1, 1'b1, 1'b1, 32'h0040_0300);
        resetn = 1'b0; repeat (2) step(); resetn = 1'b1;
        repeat (20) step();
        resetn = 1'b0; repeat (2) step();
        chk("rst2_ready", {31'd0, ready}, 32'd0);
        chk("rst2_stat_lk", stat_lookups, 32'd0);
        chk("rst2_stat_mp", stat_mispredicts, 32'd0);
        resetn = 1'b1;
        wait_ready(0, cnt);
        chk("rst2_len", cnt, 32'd64);
        lookup(32'h0040_0030);
        chk("rst2_miss", {31'd0, pred_taken}, 32'd0);
        lookup(32'h0040_0010);
        fe_valid = 1'b1; fe_pc = 32'h0040_0000;
        update(32'h0040_0060, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0040_0800);
        fe_valid = 1'b0;
        chk("rst2_redir_pc", redirect_pc, 32'h0040_0064);
        chk("stat_lookups", stat_lookups, stat_exp(32'd3));
        chk("stat_mispredicts", stat_mispredicts, stat_exp(32'd1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
